and16_stream_unit: RTL

// - Handshaked, buffered 16-bit bitwise AND engine: the responder side of a

---
 rtl/and16_stream_unit.sv | 100 ++++++++++
 1 files changed

// File: rtl/and16_stream_unit.sv
// and16_stream_unit: handshaked, buffered bitwise AND engine.
// Operand pairs (a, b) come in on a valid/ready request channel. Each accepted
// pair is reduced to a & b at the accepting edge and queued in an in-order
// result FIFO. The FIFO head is presented on a valid/ready response channel.
// Optional feature macro: AND16_STREAM_NAND_EN adds a per-request req_op bit
// (0: a & b, 1: ~(a & b)).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_a, req_b          operands (WIDTH bits)
//   req_op                result select (only with AND16_STREAM_NAND_EN)
//   rsp_valid/rsp_ready   response handshake
//   rsp_out               registered FIFO head, 0 when empty
//   level                 FIFO occupancy
//   op_count              accepted-request counter, wraps at 16 bits
module and16_stream_unit #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [WIDTH-1:0]           req_a,
   input  logic [WIDTH-1:0]           req_b,
`ifdef AND16_STREAM_NAND_EN
   input  logic                       req_op,
`endif
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [WIDTH-1:0]           rsp_out,
   output logic [$clog2(DEPTH):0]     level,
   output logic [15:0]                op_count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   logic             push_c;
   logic             pop_c;
   logic [WIDTH-1:0] result_c;
   logic [LW-1:0]    remain_c;
   logic [LW-1:0]    level_nxt_c;
   logic [PW-1:0]    wr_nxt_c;
   logic [PW-1:0]    rd_nxt_c;
   logic [WIDTH-1:0] head_nxt_c;

   // Handshakes, result computation and next FIFO state.
   always_comb begin
      push_c      = req_valid & req_ready;
      pop_c       = rsp_valid & rsp_ready;
`ifdef AND16_STREAM_NAND_EN
      result_c    = req_op ? ~(req_a & req_b) : (req_a & req_b);
`else
      result_c    = req_a & req_b;
`endif
      remain_c    = level - LW'(pop_c);
      level_nxt_c = remain_c + LW'(push_c);
      wr_nxt_c    = push_c ? wr_ptr + PW'(1) : wr_ptr;
      rd_nxt_c    = pop_c  ? rd_ptr + PW'(1) : rd_ptr;
      head_nxt_c  = '0;
      // The pushed entry only becomes the head when nothing older remains.
      if (level_nxt_c != '0) begin
         if (push_c && (remain_c == '0)) head_nxt_c = result_c;
         else                            head_nxt_c = mem[rd_nxt_c];
      end
   end

   // Result storage; written only on an accepted request.
   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr] <= result_c;
   end

   // Pointers, occupancy, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         op_count  <= '0;
         rsp_valid <= 1'b0;
         rsp_out   <= '0;
         req_ready <= 1'b0;
      end else begin
         wr_ptr    <= wr_nxt_c;
         rd_ptr    <= rd_nxt_c;
         level     <= level_nxt_c;
         op_count  <= op_count + 16'(push_c);
         rsp_valid <= (level_nxt_c != '0);
         rsp_out   <= head_nxt_c;
         // Depends on occupancy only: a pop while full frees space next cycle.
         req_ready <= (level_nxt_c < LW'(DEPTH));
      end
   end

endmodule
